melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer.sv | 148 ++++++++++++++
 tb/tb_melody_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Plays a fixed 14-step melody, with a repeated tail section, as one-hot notes; passes manual keys through when idle.
// Latency: note_out is registered one cycle behind state. No backpressure: pause freezes playback, stop aborts it.
module melody_sequencer #(
    parameter int BEAT_CYCLES = 16000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int LOOP_START  = 7,
    parameter int LOOP_COUNT  = 4
) (
    input  logic       CLOCK_27,
    input  logic       Reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [7:0] manual_notes,
    output logic [7:0] note_out,
    output logic       busy,
    output logic [3:0] step,
    output logic       done
);

    localparam int BW = (BEAT_CYCLES > 2) ? $clog2(BEAT_CYCLES) : 1;
    localparam int LW = $clog2(LOOP_COUNT + 2);
    localparam logic [BW-1:0] PLAY_LAST = BW'(BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    localparam logic [LW-1:0] LOOP_MAX  = LW'(LOOP_COUNT);
    localparam logic [3:0]    LOOP_STEP = 4'(LOOP_START);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [3:0]    step_q, step_d;
    logic [LW-1:0] loop_q, loop_d;
    logic [7:0]    note_q, note_d;
    logic          done_q, done_d;
    logic          advance;
    logic          go_idle;

    function automatic logic [7:0] rom_note(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd13:  rom_note = 8'h01;
            4'd2, 4'd3, 4'd6:   rom_note = 8'h10;
            4'd4, 4'd5:         rom_note = 8'h20;
            4'd7, 4'd8:         rom_note = 8'h08;
            4'd9, 4'd10:        rom_note = 8'h04;
            4'd11, 4'd12:       rom_note = 8'h02;
            default:            rom_note = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        step_d  = step_q;
        loop_d  = loop_q;
        note_d  = note_q;
        done_d  = 1'b0;
        advance = 1'b0;
        go_idle = 1'b0;

        case (state_q)
            IDLE: begin
                note_d = manual_notes;
                if (start && !stop) begin
                    state_d = PLAY;
                    beat_d  = '0;
                    step_d  = 4'd0;
                    loop_d  = '0;
                end
            end
            PLAY: begin
                // pause holds the last registered note; stop still lets the mux update
                if (!pause || stop) note_d = rom_note(step_q);
                if (stop) begin
                    go_idle = 1'b1;
                end else if (!pause) begin
                    if (beat_q == PLAY_LAST) begin
                        if (GAP_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = GAP;
                            beat_d  = beat_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (!pause || stop) note_d = 8'h00;
                if (stop) begin
                    go_idle = 1'b1;
                end else if (!pause) begin
                    if (beat_q == BEAT_LAST) advance = 1'b1;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (advance) begin
            state_d = PLAY;
            beat_d  = '0;
            if (step_q == 4'd13) begin
                if (loop_q < LOOP_MAX) begin
                    loop_d = loop_q + 1'b1;
                    step_d = LOOP_STEP;
                end else begin
                    go_idle = 1'b1;
                    done_d  = 1'b1;
                end
            end else begin
                step_d = step_q + 4'd1;
            end
        end

        if (go_idle) begin
            state_d = IDLE;
            beat_d  = '0;
            step_d  = 4'd0;
            loop_d  = '0;
        end
    end

    always_ff @(posedge CLOCK_27 or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            step_q  <= 4'd0;
            loop_q  <= '0;
            note_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            loop_q  <= loop_d;
            note_q  <= note_d;
            done_q  <= done_d;
        end
    end

    assign note_out = note_q;
    assign busy     = (state_q != IDLE);
    assign step     = step_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios then random control traffic, checked each cycle
// against an elapsed-time song model.
module tb_melody_sequencer;

    localparam int BEAT   = 10;
    localparam int GAP    = 2;
    localparam int LSTART = 7;
    localparam int LCOUNT = 1;
    localparam int NSTEPS = 14 + (14 - LSTART) * LCOUNT;
    localparam int TOTAL  = NSTEPS * BEAT;

    logic       clk = 1'b0;
    logic       Reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic [7:0] manual_notes;
    logic [7:0] note_out;
    logic       busy;
    logic [3:0] step;
    logic       done;

    melody_sequencer #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP),
        .LOOP_START (LSTART),
        .LOOP_COUNT (LCOUNT)
    ) dut (
        .CLOCK_27    (clk),
        .Reset       (Reset),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .manual_notes(manual_notes),
        .note_out    (note_out),
        .busy        (busy),
        .step        (step),
        .done        (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    // model: song position as elapsed playing cycles
    bit         m_play;
    int         m_t;
    logic [7:0] m_note;
    bit         m_done;
    logic [7:0] rom_tab [14];

    function automatic int song_idx(input int t);
        int k;
        k = t / BEAT;
        return (k < 14) ? k : LSTART + (k - 14) % (14 - LSTART);
    endfunction

    function automatic logic [7:0] song_note(input int t);
        return ((t % BEAT) < (BEAT - GAP)) ? rom_tab[song_idx(t)] : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_play = 1'b0;
        m_t    = 0;
        m_note = 8'h00;
        m_done = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] nn;
        bit         nd;
        if (!Reset) begin
            model_reset();
            return;
        end
        if (m_play && pause && !stop) nn = m_note;
        else if (m_play)              nn = song_note(m_t);
        else                          nn = manual_notes;
        nd = m_play && !stop && !pause && (m_t == TOTAL - 1);
        if (m_play) begin
            if (stop) m_play = 1'b0;
            else if (!pause) begin
                if (m_t == TOTAL - 1) m_play = 1'b0;
                else                  m_t++;
            end
        end else if (start && !stop) begin
            m_play = 1'b1;
            m_t    = 0;
        end
        m_note = nn;
        m_done = nd;
    endtask

    task automatic check_outputs();
        check("note", note_out, m_note);
        check("busy", busy, m_play);
        check("done", done, m_done);
        check("step", step, m_play ? song_idx(m_t) : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic wait_pos(input int idx, input int phase);
        int n;
        n = 0;
        while (!(m_play && song_idx(m_t) == idx && (m_t % BEAT) == phase) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $error("FAIL wait_pos: observed=timeout expected=step%0d phase%0d", idx, phase);
        end
    endtask

    initial begin
        rom_tab = '{8'h01, 8'h01, 8'h10, 8'h10, 8'h20, 8'h20, 8'h10,
                    8'h08, 8'h08, 8'h04, 8'h04, 8'h02, 8'h02, 8'h01};
        Reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; manual_notes = 8'h00;
        model_reset();

        // reset state
        #2;
        check_outputs();
        repeat (2) tick();
        Reset = 1'b1;

        // idle pass-through
        manual_notes = 8'h40;
        tick();
        check("idle_manual40", note_out, 8'h40);
        manual_notes = 8'h05;
        tick();
        tick();

        // first beats and a full run
        busy_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (i == 3) manual_notes = 8'h80;
            check("beat_pattern", note_out,
                  (i < 8) ? 8'h01 : (i < 10) ? 8'h00 : (i < 18) ? 8'h01 : (i < 20) ? 8'h00 : 8'h10);
        end
        for (int n = 0; n < 400 && busy; n++) tick();
        check("song_busy_cycles", busy_cnt, TOTAL);
        check("song_done_pulses", done_cnt, 1);
        tick();
        check("after_song_manual", note_out, 8'h80);

        // start held: pause in step 4, then restart right after done
        start = 1'b1;
        tick();
        wait_pos(4, 3);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("pause_note", note_out, 8'h20);
            check("pause_step", step, 4);
        end
        pause = 1'b0;
        for (int n = 0; n < 400 && !done; n++) tick();
        check("done_seen", done, 1);
        tick();
        check("restart_busy", busy, 1);
        start = 1'b0;

        // stop in step 9, then start+stop together
        wait_pos(9, 2);
        stop = 1'b1;
        tick();
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        start = 1'b1;
        tick();
        check("start_stop_idle", busy, 0);
        start = 1'b0;
        stop  = 1'b0;
        tick();

        // asynchronous reset in step 6 gap
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_pos(6, 8);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) tick();
        Reset = 1'b1;
        manual_notes = 8'h22;
        repeat (3) tick();
        check("post_reset_idle", busy, 0);
        check("post_reset_manual", note_out, 8'h22);

        // random control traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 8) == 0;
            stop  = ($urandom % 60) == 0;
            pause = ($urandom % 6) == 0;
            if (($urandom % 4) == 0) manual_notes = 8'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
